// File: rtl/opn_seq_pkg.sv
// Shared types and constants for the OPN register-write sequencer.
// Imported by opn_bus_writer and opn_reg_sequencer.
package opn_seq_pkg;

  // ST_WRITE is where the sequencer waits while the bus writer walks A_LO..D_HI.
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_A_LO, ST_A_HI, ST_D_LO, ST_D_HI, ST_GAP, ST_WRITE
  } seq_state_e;

  localparam int ENT_BANK  = 17;
  localparam int ENT_PERCH = 16;
  localparam logic [7:0] REG_KON = 8'h28;

  function automatic logic [2:0] ch_map(input logic [2:0] ch);
    if (ch >= 3'd3) return {1'b1, 2'(ch - 3'd3)};
    return {1'b0, ch[1:0]};
  endfunction

endpackage

// File: rtl/opn_bus_writer.sv
// One two-phase (address then data) host-bus write to the FM/PSG core.
// Accepts go when idle, raises ack on the last D_HI cycle.
module opn_bus_writer
  import opn_seq_pkg::*;
#(
  parameter int PULSE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       go,
  input  logic       bank,
  input  logic [7:0] reg_byte,
  input  logic [7:0] val_byte,
  output logic       ack,
  output logic       cs_n,
  output logic       wr_n,
  output logic [1:0] addr,
  output logic [7:0] dout
);

  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  seq_state_e     phase, phase_next;
  logic [PW-1:0]  cnt;
  logic [7:0]     val_q;
  logic           pulse_end;

  assign pulse_end = (cnt == PW'(PULSE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= ST_IDLE;
      cnt   <= '0;
      val_q <= '0;
      addr  <= '0;
      dout  <= '0;
    end else if (cen) begin
      phase <= phase_next;
      if (phase == ST_IDLE || pulse_end) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      if (phase == ST_IDLE && go) begin
        addr  <= {bank, 1'b0};
        dout  <= reg_byte;
        val_q <= val_byte;
      end else if (phase == ST_A_HI && pulse_end) begin
        addr[0] <= 1'b1;
        dout    <= val_q;
      end
    end
  end

  always_comb begin
    phase_next = phase;
    ack        = 1'b0;
    case (phase)
      ST_IDLE: if (go)        phase_next = ST_A_LO;
      ST_A_LO: if (pulse_end) phase_next = ST_A_HI;
      ST_A_HI: if (pulse_end) phase_next = ST_D_LO;
      ST_D_LO: if (pulse_end) phase_next = ST_D_HI;
      ST_D_HI: if (pulse_end) begin
        phase_next = ST_IDLE;
        ack        = cen;
      end
      default: phase_next = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the phase register so they freeze with cen.
  assign cs_n = (phase == ST_IDLE);
  assign wr_n = !(phase == ST_A_LO || phase == ST_D_LO);

endmodule

// File: rtl/opn_reg_sequencer.sv
// Table-driven register-write sequencer for the OPN core host bus.
// Optional SEQ_BUSY_POLL_EN: poll the chip busy flag during the gap.
module opn_reg_sequencer
  import opn_seq_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int BANKS     = 2,
  parameter int PULSE_CYC = 1,
  parameter int WAIT_CYC  = 476,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          cen,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [17:0]   tbl_data,
  input  logic [AW:0]   len,
  input  logic [2:0]    nch,
  input  logic          start,
`ifdef SEQ_BUSY_POLL_EN
  input  logic [7:0]    din_status,
  output logic          rd_n,
`endif
  output logic          busy,
  output logic          done,
  output logic          cs_n,
  output logic          wr_n,
  output logic [1:0]    addr,
  output logic [7:0]    dout
);

  localparam int GW = $clog2(WAIT_CYC + 1);
  localparam logic [2:0] NCH_MAX = 3'(3 * BANKS);

  logic [17:0]   table_mem [DEPTH];
  seq_state_e    state, state_next;
  logic [AW-1:0] idx;
  logic [AW:0]   len_q;
  logic [2:0]    nch_q, ch, nch_eff, map;
  logic [GW-1:0] gap_cnt;
  logic [17:0]   entry;
  logic [7:0]    reg_eff;
  logic          bank_eff, gap_end, last_ch, last_entry, go, ack;
  logic          wr_cs_n;
  logic [1:0]    wr_addr;

  always_ff @(posedge clk_in) begin
    if (tbl_we && state == ST_IDLE) table_mem[tbl_addr] <= tbl_data;
  end

  assign entry    = table_mem[idx];
  assign map      = ch_map(ch);
  assign reg_eff  = entry[ENT_PERCH] ? entry[15:8] + {6'd0, map[1:0]} : entry[15:8];
  assign bank_eff = entry[ENT_PERCH] ? map[2] : ((BANKS == 2) ? entry[ENT_BANK] : 1'b0);
  assign nch_eff  = (nch == 3'd0) ? 3'd1 : ((nch > NCH_MAX) ? NCH_MAX : nch);

  assign last_ch    = !entry[ENT_PERCH] || (ch == nch_q - 3'd1);
  assign last_entry = ({1'b0, idx} == len_q - 1'b1);
  assign go         = (state == ST_FETCH);
  assign busy       = (state != ST_IDLE);

`ifdef SEQ_BUSY_POLL_EN
  logic polling, sample;
  assign polling = (state == ST_GAP) && (gap_cnt >= GW'(32));
  assign sample  = polling && (gap_cnt[2:0] == 3'd7);
  assign gap_end = (sample && !din_status[7]) || (gap_cnt == GW'(WAIT_CYC - 1));
  assign rd_n    = !polling;
  assign cs_n    = wr_cs_n && !polling;
  assign addr    = polling ? 2'b00 : wr_addr;
`else
  assign gap_end = (gap_cnt == GW'(WAIT_CYC - 1));
  assign cs_n    = wr_cs_n;
  assign addr    = wr_addr;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      ch      <= '0;
      len_q   <= '0;
      nch_q   <= '0;
      gap_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cen) begin
        state <= state_next;
        case (state)
          ST_IDLE: if (start) begin
            len_q <= len;
            nch_q <= nch_eff;
            idx   <= '0;
            ch    <= '0;
            done  <= (len == '0);
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_end) begin
              gap_cnt <= '0;
              if (!last_ch)        ch <= ch + 1'b1;
              else begin
                ch <= '0;
                if (last_entry)    done <= 1'b1;
                else               idx  <= idx + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start && len != '0) state_next = ST_FETCH;
      ST_FETCH: state_next = ST_WRITE;
      ST_WRITE: if (ack) state_next = ST_GAP;
      ST_GAP:   if (gap_end) state_next = (last_ch && last_entry) ? ST_IDLE : ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  opn_bus_writer #(.PULSE_CYC(PULSE_CYC)) u_writer (
    .clk      (clk_in),
    .rst      (rst),
    .cen      (cen),
    .go       (go),
    .bank     (bank_eff),
    .reg_byte (reg_eff),
    .val_byte (entry[7:0]),
    .ack      (ack),
    .cs_n     (wr_cs_n),
    .wr_n     (wr_n),
    .addr     (wr_addr),
    .dout     (dout)
  );

endmodule

// File: tb/tb_opn_reg_sequencer.sv
// Self-checking bench for opn_reg_sequencer (default build, SEQ_BUSY_POLL_EN undefined).
// A timeline model derived from the write list predicts every bus cycle.
module tb_opn_reg_sequencer;

  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int BANKS    = 2;
  localparam int WAIT_CYC = 476;
  localparam int P        = 5 + WAIT_CYC;

  logic          clk = 1'b0, rst = 1'b1, cen = 1'b1, tbl_we = 1'b0, start = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [17:0]   tbl_data = '0;
  logic [AW:0]   len = '0;
  logic [2:0]    nch = 3'd1;
  logic          busy, done, cs_n, wr_n;
  logic [1:0]    addr;
  logic [7:0]    dout;

  int n_checks = 0, n_pass = 0;
  int cen_mode = 0;
  logic [17:0] mtbl [DEPTH];
  logic [16:0] wq [$];
  int mt = -1, n_writes = 0;

  opn_reg_sequencer #(.DEPTH(DEPTH), .BANKS(BANKS), .PULSE_CYC(1), .WAIT_CYC(WAIT_CYC)) dut (
    .clk_in(clk), .rst(rst), .cen(cen), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .len(len), .nch(nch), .start(start), .busy(busy),
    .done(done), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .dout(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = ~cen;
      default: cen = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Expand the table into the ordered list of {bank, reg, val} bus writes.
  task automatic build_model(input logic [AW:0] l, input logic [2:0] n);
    int nc;
    logic [17:0] e;
    wq.delete();
    nc = (n == 0) ? 1 : ((n > 3 * BANKS) ? 3 * BANKS : int'(n));
    for (int i = 0; i < int'(l); i++) begin
      e = mtbl[i];
      if (e[16]) begin
        for (int c = 0; c < nc; c++) wq.push_back({1'(c / 3), 8'(e[15:8] + 8'(c % 3)), e[7:0]});
      end else begin
        wq.push_back({(BANKS == 2) ? e[17] : 1'b0, e[15:8], e[7:0]});
      end
    end
    n_writes = wq.size();
  endtask

  always @(posedge clk) begin
    logic s_rst, s_cen, s_start, s_we;
    logic [AW-1:0] s_addr;
    logic [17:0] s_data;
    logic [AW:0] s_len;
    logic [2:0] s_nch;
    logic [3:0] ectl;
    logic [16:0] x;
    int w, p;
    s_rst = rst; s_cen = cen; s_start = start; s_we = tbl_we;
    s_addr = tbl_addr; s_data = tbl_data; s_len = len; s_nch = nch;
    if (s_rst) mt = -1;
    else if (mt < 0) begin
      if (s_we) mtbl[s_addr] = s_data;
      if (s_start && s_cen) begin
        build_model(s_len, s_nch);
        mt = 0;
      end
    end else if (s_cen) mt++;
    #1;
    if (mt < 0) begin
      check_output("idle", {busy, done, cs_n, wr_n}, 4'b0011);
    end else if (mt == n_writes * P) begin
      check_output("done", {busy, done, cs_n, wr_n}, 4'b0111);
      mt = -1;
    end else begin
      w = mt / P;
      p = mt % P;
      x = wq[w];
      case (p)
        0:       ectl = 4'b1011;
        1, 3:    ectl = 4'b1000;
        2, 4:    ectl = 4'b1001;
        default: ectl = 4'b1011;
      endcase
      if (p == 1 || p == 2)
        check_output($sformatf("bus w%0d p%0d", w, p), {busy, done, cs_n, wr_n, addr, dout},
                     {ectl, x[16], 1'b0, x[15:8]});
      else if (p == 3 || p == 4)
        check_output($sformatf("bus w%0d p%0d", w, p), {busy, done, cs_n, wr_n, addr, dout},
                     {ectl, x[16], 1'b1, x[7:0]});
      else
        check_output($sformatf("bus w%0d p%0d", w, p), {busy, done, cs_n, wr_n}, ectl);
    end
  end

  task automatic write_entry(input int i, input logic [17:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = AW'(i); tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start(input int l, input int n);
    @(negedge clk);
    while (!cen) @(negedge clk);
    len = (AW+1)'(l); nch = 3'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start a run and wait (bounded) for done; optionally poke start/tbl_we mid-run.
  task automatic apply_stimulus(input int l, input int n, input bit poke,
                                output int busy_clks, output int done_clk);
    int guard;
    bit got;
    guard = 0; got = 0; busy_clks = 0; done_clk = 0;
    pulse_start(l, n);
    while (!got && guard < 40000) begin
      if (busy) busy_clks++;
      if (done) begin
        got = 1;
        done_clk = guard + 1;
      end else begin
        @(negedge clk);
        guard++;
        if (poke && guard == 10) begin
          start = 1'b1; len = 3; tbl_we = 1'b1; tbl_addr = '0; tbl_data = 18'h0FFFF;
        end else if (poke && guard == 11) begin
          start = 1'b0; tbl_we = 1'b0;
        end
      end
    end
    check_output("done seen", 32'(got), 32'd1);
  endtask

  initial begin
    int bc, dc, l, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset outputs", {busy, done, cs_n, wr_n, addr, dout}, {4'b0011, 2'b00, 8'h00});

    apply_stimulus(0, 1, 0, bc, dc);
    check_output("len0 busy clocks", bc, 0);
    check_output("len0 done latency", dc, 1);

    write_entry(0, {1'b0, 1'b0, 8'hB0, 8'h07});
    apply_stimulus(1, 1, 0, bc, dc);
    check_output("single write list", {15'(wq.size()), wq[0]}, {15'd1, 17'h0B007});
    check_output("single busy clocks", bc, 481);

    write_entry(0, {1'b0, 1'b1, 8'hA0, 8'h0F});
    apply_stimulus(1, 6, 0, bc, dc);
    check_output("perch write count", wq.size(), 6);
    check_output("perch ch2", wq[2], {1'b0, 8'hA2, 8'h0F});
    check_output("perch ch3", wq[3], {1'b1, 8'hA0, 8'h0F});
    check_output("perch ch5", wq[5], {1'b1, 8'hA2, 8'h0F});
    check_output("perch busy clocks", bc, 6 * 481);

    write_entry(0, {1'b0, 1'b0, 8'hB0, 8'h07});
    cen_mode = 1;
    apply_stimulus(1, 1, 0, bc, dc);
    check_output("half rate busy clocks", bc, 962);
    cen_mode = 0;
    repeat (2) @(negedge clk);

    write_entry(1, {1'b1, 1'b0, 8'h30, 8'h71});
    pulse_start(2, 1);
    repeat (3) @(negedge clk);
    check_output("in D_LO", {cs_n, wr_n, addr[0]}, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    check_output("bus released on reset", {busy, cs_n, wr_n}, 3'b011);
    rst = 1'b0;
    apply_stimulus(2, 1, 0, bc, dc);
    check_output("replay entry1", wq[1], {1'b1, 8'h30, 8'h71});
    check_output("replay busy clocks", bc, 962);

    apply_stimulus(1, 1, 1, bc, dc);
    check_output("start while busy ignored", bc, 481);
    apply_stimulus(1, 1, 0, bc, dc);
    check_output("entry0 unchanged", wq[0], 17'h0B007);

    cen_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 2; i++)
        write_entry(i, {1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom)});
      l = $urandom_range(0, 2);
      n = $urandom_range(0, 7);
      apply_stimulus(l, n, 0, bc, dc);
    end
    cen_mode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
